crypt_out_buffer: RTL

//  Downstream stage of the 64-bit block cipher engine. Captures each single-cycle result/result_vld

---
 rtl/crypt_out_buffer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/crypt_out_buffer.sv
// Cipher output FIFO: stores 64-bit blocks and serializes each as two 32-bit beats (high half first).
// Optional drop counter output when CRYPT_OBUF_DROP_CNT_EN is defined.
//   state | meaning
//   IDLE  | nothing presented, out_vld low
//   HI    | presenting head[63:32] (cipher bits 0..31)
//   LO    | presenting head[31:0], out_last high; handshake pops the head
module crypt_out_buffer #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   in_data,
  input  logic          in_vld,
  output logic [31:0]   out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          out_last,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          ovf,
`ifdef CRYPT_OBUF_DROP_CNT_EN
  output logic [7:0]    drop_cnt,
`endif
  input  logic          ovf_clr
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_nxt;
  logic [63:0]   head;
  logic [63:0]   next_head;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // in_data[63] carries cipher bit 0 (MSB), so head[63:32] is the cipher's [0:31] half
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + PTR_ONE];
  assign pop       = (state == LO) && out_rdy;
  assign wr_en     = in_vld && (!full || pop);
  assign drop      = in_vld && full && !pop;

  always_comb begin
    level_nxt = level;
    if (wr_en && !pop)
      level_nxt = level + LVL_ONE;
    else if (!wr_en && pop)
      level_nxt = level - LVL_ONE;
  end

  // Storage has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_FULL);
      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

`ifdef CRYPT_OBUF_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (ovf_clr)
      drop_cnt <= {7'd0, drop};
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

  // On the LO pop, the next head is already stored whenever level > 1, so HI follows with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            state    <= HI;
            out_vld  <= 1'b1;
            out_last <= 1'b0;
            out_data <= head[63:32];
          end
        end
        HI: begin
          if (out_rdy) begin
            state    <= LO;
            out_last <= 1'b1;
            out_data <= head[31:0];
          end
        end
        LO: begin
          if (out_rdy) begin
            if (level > LVL_ONE) begin
              state    <= HI;
              out_last <= 1'b0;
              out_data <= next_head[63:32];
            end else begin
              state    <= IDLE;
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              out_data <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          out_vld  <= 1'b0;
          out_last <= 1'b0;
          out_data <= '0;
        end
      endcase
    end
  end

endmodule
